qupls_rf_write_arbiter: RTL
===========================

# qupls_rf_write_arbiter

Result-writeback arbiter that sits directly upstream of the 4-write-port physical register file. It collects completed results from NSRC functional-unit sources, buffers each in a 2-entry FIFO, and each cycle grants up to four of them in round-robin order onto registered write ports 0–3. Register 0 (tag low 6 bits zero) is never written, and two ports never carry the same tag in one cycle.

## Interface
- WID, 64: result data width.
- RBIT, 8: physical register tag is RBIT+1 bits.
- NSRC, 8: number of result sources, 4..16.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low, synchronous deassert by user.
- src_valid  in  [NSRC]  source presents a result.
- src_ready  out  [NSRC]  arbiter can accept from that source.
- src_tag  in  [NSRC][RBIT+1]  destination physical register.
- src_data  in  [NSRC][WID]  result value.
- wr0..wr3  out  1 each  write-port enable.
- we0..we3  out  1 each  write enable; always equal to the matching wrN.
- wa0..wa3  out  RBIT+1 each  write address.
- i0..i3  out  WID each  write data.
- idle  out  1  all buffers empty and no write in flight.

## Operation
- Each source has a 2-entry FIFO. src_ready[s] = (count[s] < 2), taken from the registered count. A transfer occurs when src_valid & src_ready. A full FIFO never bypasses.
- Eligible head: FIFO non-empty.
- Zero-tag discard: a head with tag[5:0]==0 is popped without consuming a port and does not count toward the 4 grants.
- Arbitration runs combinationally on the heads. Scan s = rr, rr+1, … modulo NSRC.
  - The first four eligible heads with a non-zero tag go to ports 0,1,2,3 in scan order.
  - A head whose tag equals a tag already granted this cycle is skipped. It stays at its head and competes next cycle.
- Granted and discarded heads pop on the clock edge. Port registers load {wrN=1, waN, iN}. Unused ports load wrN=0; waN and iN hold their previous values.
- Pointer update: if any port was granted, rr <= (index of last granted source + 1) mod NSRC. Otherwise rr is unchanged. Discards do not move rr.
- Simultaneous push and pop on the same FIFO in one cycle is legal; count is unchanged.
- idle = all counts zero and wr0..wr3 all zero.

## Timing
- Reset (rst low, asynchronous):
  - all FIFOs empty, rr=0;
  - wr*/we*=0, wa*=0, i*=0;
  - src_ready=0 while reset is asserted;
  - idle=1.
- First cycle after release: src_ready all 1.
- Latency: a result accepted at edge N is at the FIFO head in cycle N+1. If granted, it is registered at edge N+1 and drives wrK during cycle N+2. Minimum latency is 2 cycles.
- Throughput: 4 writes per cycle in aggregate, 1 per source per cycle.
- Starvation bound: an eligible non-duplicate head is granted within ceil(NSRC/4) cycles.
- Reset asserted mid-operation drops all buffered results; no write port asserts afterwards.

## Structure
- QuplsPkg holds:
  - PREGS and RBIT;
  - typedef wb_result_t {tag [RBIT:0]; data [WID-1:0]};
  - constant NWRPORTS = 4.
- Sub-module qupls_wb_fifo2: 2-entry FIFO of wb_result_t with push, pop, head, count. Instantiated NSRC times in a generate loop.
- The arbiter scan is an always_comb loop. The port registers and rr live in a single always_ff with async active-low reset.

## Test plan
- Reset and basic path:
  - Stimulus: hold rst low with src_valid=all ones, then release; next cycle source 2 presents tag 9'h041, data 64'hDEAD.
  - Required: all outputs 0 and src_ready=0 during reset; after release wr0=1, wa0=9'h041, i0=64'hDEAD exactly 2 cycles after acceptance, we0=wr0, idle=1 one cycle later.
- Round-robin with full load: all 8 sources present distinct tags every cycle. Required grants:
  - cycle A: sources 0–3 on ports 0–3;
  - cycle B: sources 4–7;
  - rr returns to 0; no source starves.
- Zero-tag discard: source 1 tag 9'h100 (low bits zero) and source 3 tag 9'h005. Required: only wr0=1 with wa0=9'h005; source 1's FIFO empties in the same cycle.
- Duplicate tag: sources 0 and 5 both tag 9'h022 in the same cycle, with rr=0. Required: source 0 written on port 0; source 5 written on port 0 in the following cycle; never two ports with the same address in one cycle.
- Back-pressure: hold source 4 ready-blocked by filling its FIFO while rr starts at 5 and sources 5..7, 0..3 stream continuously. Required: src_ready[4]=0 while count=2; source 4 is granted within 2 cycles; no data loss or reorder within source 4.
- Mid-operation reset: assert rst with 6 entries buffered. Required: outputs clear immediately (asynchronously); after release no stale writes appear and idle=1.

Source files
------------

// File: rtl/qupls_rf_write_arbiter_pkg.sv
// Shared widths and the writeback result record for the register-file write arbiter.
package qupls_rf_write_arbiter_pkg;
  localparam int WID      = 64;
  localparam int RBIT     = 8;
  localparam int PREGS    = 512;
  localparam int NSRC     = 8;
  localparam int NWRPORTS = 4;

  typedef struct packed {
    logic [RBIT:0]  tag;
    logic [WID-1:0] data;
  } wb_result_t;

  // Physical register 0 in every bank is hardwired; writes to it are dropped.
  function automatic logic is_r0(input logic [RBIT:0] tag);
    return tag[5:0] == 6'd0;
  endfunction
endpackage

// File: rtl/qupls_rf_write_arbiter_if.sv
// Source-side handshake and register-file write-port bundle of the writeback arbiter.
interface qupls_rf_write_arbiter_if
  import qupls_rf_write_arbiter_pkg::*;
  #(parameter int NSRC = 8) ();
  logic [NSRC-1:0]           src_valid;
  logic [NSRC-1:0]           src_ready;
  logic [NSRC-1:0][RBIT:0]   src_tag;
  logic [NSRC-1:0][WID-1:0]  src_data;
  logic                      wr0, wr1, wr2, wr3;
  logic                      we0, we1, we2, we3;
  logic [RBIT:0]             wa0, wa1, wa2, wa3;
  logic [WID-1:0]            i0, i1, i2, i3;
  logic                      idle;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, wr0, wr1, wr2, wr3, we0, we1, we2, we3,
    input  wa0, wa1, wa2, wa3, i0, i1, i2, i3, idle
  );
  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, wr0, wr1, wr2, wr3, we0, we1, we2, we3,
    output wa0, wa1, wa2, wa3, i0, i1, i2, i3, idle
  );
endinterface

// File: rtl/qupls_wb_fifo2.sv
// Two-entry FIFO holding pending writeback results for one source.
module qupls_wb_fifo2
  import qupls_rf_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  wb_result_t din,
  output wb_result_t head,
  output logic [1:0] count
);
  wb_result_t mem [2];
  logic       rd, wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd    <= 1'b0;
      wr    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wr <= ~wr;
      if (pop)  rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage needs no reset; count gates every use of the head.
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;

  assign head = mem[rd];
endmodule

// File: rtl/qupls_rf_write_arbiter.sv
// Round-robin writeback arbiter: per-source 2-deep buffers feeding four registered RF write ports.
module qupls_rf_write_arbiter
  import qupls_rf_write_arbiter_pkg::*;
  #(parameter int NSRC = 8)
(
  input  logic                    clk,
  input  logic                    rst,
  qupls_rf_write_arbiter_if.slave bus
);
  localparam int SW = $clog2(NSRC);

  wb_result_t      din  [NSRC];
  wb_result_t      head [NSRC];
  logic [1:0]      cnt  [NSRC];
  logic [NSRC-1:0] push, pop, nz;

  generate
    for (genvar g = 0; g < NSRC; g++) begin : g_src
      assign bus.src_ready[g] = rst & (cnt[g] < 2'd2);
      assign push[g]          = bus.src_valid[g] & bus.src_ready[g];
      assign din[g]           = '{tag: bus.src_tag[g], data: bus.src_data[g]};
      assign nz[g]            = |cnt[g];

      qupls_wb_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[g]),
        .pop   (pop[g]),
        .din   (din[g]),
        .head  (head[g]),
        .count (cnt[g])
      );
    end
  endgenerate

  logic [SW-1:0]                   rr, rr_nxt, s;
  logic [SW:0]                     sx;
  logic [2:0]                      ng;
  logic                            dup;
  logic [NWRPORTS-1:0]             gv;
  logic [NWRPORTS-1:0][RBIT:0]     gtag;
  logic [NWRPORTS-1:0][WID-1:0]    gdat;

  // Scan from rr; r0 heads are dropped free, duplicates wait for a later cycle.
  always_comb begin
    pop    = '0;
    gv     = '0;
    gtag   = '0;
    gdat   = '0;
    rr_nxt = rr;
    ng     = 3'd0;
    dup    = 1'b0;
    sx     = '0;
    s      = '0;
    for (int k = 0; k < NSRC; k++) begin
      sx = {1'b0, rr} + (SW+1)'(k);
      if (sx >= (SW+1)'(NSRC)) sx = sx - (SW+1)'(NSRC);
      s = sx[SW-1:0];
      if (cnt[s] != 2'd0) begin
        if (is_r0(head[s].tag)) begin
          pop[s] = 1'b1;
        end else if (ng < 3'(NWRPORTS)) begin
          dup = 1'b0;
          for (int j = 0; j < NWRPORTS; j++)
            if (gv[j[1:0]] && gtag[j[1:0]] == head[s].tag) dup = 1'b1;
          if (!dup) begin
            gv[ng[1:0]]   = 1'b1;
            gtag[ng[1:0]] = head[s].tag;
            gdat[ng[1:0]] = head[s].data;
            pop[s]        = 1'b1;
            ng            = ng + 3'd1;
            rr_nxt        = (s == SW'(NSRC-1)) ? '0 : s + 1'b1;
          end
        end
      end
    end
  end

  logic [NWRPORTS-1:0]          wr_q;
  logic [NWRPORTS-1:0][RBIT:0]  wa_q;
  logic [NWRPORTS-1:0][WID-1:0] i_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr   <= '0;
      wr_q <= '0;
      wa_q <= '0;
      i_q  <= '0;
    end else begin
      rr   <= rr_nxt;
      wr_q <= gv;
      for (int p = 0; p < NWRPORTS; p++)
        if (gv[p[1:0]]) begin
          wa_q[p[1:0]] <= gtag[p[1:0]];
          i_q[p[1:0]]  <= gdat[p[1:0]];
        end
    end
  end

  assign bus.wr0  = wr_q[0];
  assign bus.wr1  = wr_q[1];
  assign bus.wr2  = wr_q[2];
  assign bus.wr3  = wr_q[3];
  assign bus.we0  = wr_q[0];
  assign bus.we1  = wr_q[1];
  assign bus.we2  = wr_q[2];
  assign bus.we3  = wr_q[3];
  assign bus.wa0  = wa_q[0];
  assign bus.wa1  = wa_q[1];
  assign bus.wa2  = wa_q[2];
  assign bus.wa3  = wa_q[3];
  assign bus.i0   = i_q[0];
  assign bus.i1   = i_q[1];
  assign bus.i2   = i_q[2];
  assign bus.i3   = i_q[3];
  assign bus.idle = ~|nz & ~|wr_q;
endmodule
